// File: rtl/ldst_unit.sv
// Load/store unit with one outstanding request: IDLE -> ACCESS -> RESP. Latency is 1 cycle for faults and 2 cycles plus stall cycles for accesses.
// Backpressure: o_req_ready is high only in IDLE, and i_ldst_waitrequest holds ACCESS with the strobe and address stable.
module ldst_unit #(
    parameter int IW     = 32,
    parameter int STALLW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [2:0]        i_req_funct3,
    input  logic [IW-1:0]     i_req_base,
    input  logic [IW-1:0]     i_req_offset,
    input  logic [IW-1:0]     i_req_wrdata,
    input  logic [4:0]        i_req_rd,
    output logic              o_resp_valid,
    output logic [4:0]        o_resp_rd,
    output logic [IW-1:0]     o_resp_data,
    output logic              o_resp_misalign,
    output logic              o_resp_illegal,
    output logic [IW-1:0]     o_ldst_addr,
    output logic              o_ldst_rd,
    output logic              o_ldst_wr,
    output logic [IW-1:0]     o_ldst_wrdata,
    output logic [IW/8-1:0]   o_ldst_byte_en,
    input  logic [IW-1:0]     i_ldst_rddata,
    input  logic              i_ldst_waitrequest,
    output logic [STALLW-1:0] o_stall_cycles
);
    localparam int NB = IW / 8;
    localparam int L  = $clog2(NB);
    localparam logic [IW-1:0] ONES = '1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     addr_q, addr_d;
    logic [IW-1:0]     wrdata_q, wrdata_d;
    logic [IW-1:0]     resp_data_q, resp_data_d;
    logic [NB-1:0]     byte_en_q, byte_en_d;
    logic [L-1:0]      lane_q, lane_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              wr_q, wr_d;
    logic [4:0]        rd_q, rd_d;
    logic              misalign_q, misalign_d;
    logic              illegal_q, illegal_d;
    logic [STALLW-1:0] stall_q, stall_d;

    logic [IW-1:0] ea;
    logic [L-1:0]  lane;
    logic [3:0]    nbytes;
    logic          legal;
    logic          misalign;
    logic [NB-1:0] size_mask;
    logic [IW-1:0] rd_shift;
    logic [IW-1:0] keep;
    logic          sign;
    logic [IW-1:0] load_data;

    always_comb begin
        ea     = i_req_base + i_req_offset;
        lane   = ea[L-1:0];
        nbytes = 4'd1 << i_req_funct3[1:0];
        case (i_req_funct3)
            3'd0, 3'd1, 3'd2: legal = 1'b1;
            3'd3:             legal = (IW == 64);
            3'd4, 3'd5:       legal = !i_req_wr;
            3'd6:             legal = !i_req_wr && (IW == 64);
            default:          legal = 1'b0;
        endcase
        misalign = (ea[3:0] & (nbytes - 4'd1)) != 4'd0;
        for (int i = 0; i < NB; i++) begin
            size_mask[i] = (i < int'(nbytes));
        end
    end

    // Load lane extraction works from the request captured at acceptance.
    always_comb begin
        rd_shift = i_ldst_rddata >> {lane_q, 3'b000};
        case (funct3_q[1:0])
            2'd0:    begin keep = ~(ONES << 8);  sign = rd_shift[7];  end
            2'd1:    begin keep = ~(ONES << 16); sign = rd_shift[15]; end
            2'd2:    begin keep = ~(ONES << 32); sign = rd_shift[31]; end
            default: begin keep = ONES;          sign = 1'b0;         end
        endcase
        load_data = (rd_shift & keep) | ((!funct3_q[2] && sign) ? ~keep : '0);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wrdata_d    = wrdata_q;
        resp_data_d = resp_data_q;
        byte_en_d   = byte_en_q;
        lane_d      = lane_q;
        funct3_d    = funct3_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        misalign_d  = misalign_q;
        illegal_d   = illegal_q;
        stall_d     = stall_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    rd_d        = i_req_rd;
                    wr_d        = i_req_wr;
                    funct3_d    = i_req_funct3;
                    lane_d      = lane;
                    resp_data_d = '0;
                    illegal_d   = !legal;
                    misalign_d  = legal && misalign;
                    if (legal && !misalign) begin
                        addr_d    = {ea[IW-1:L], {L{1'b0}}};
                        byte_en_d = size_mask << lane;
                        wrdata_d  = i_req_wrdata << {lane, 3'b000};
                        state_d   = ACCESS;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (i_ldst_waitrequest) begin
                    if (stall_q != '1) stall_d = stall_q + STALLW'(1);
                end else begin
                    if (!wr_q && rd_q != 5'd0) resp_data_d = load_data;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wrdata_q    <= '0;
            resp_data_q <= '0;
            byte_en_q   <= '0;
            lane_q      <= '0;
            funct3_q    <= '0;
            wr_q        <= 1'b0;
            rd_q        <= '0;
            misalign_q  <= 1'b0;
            illegal_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wrdata_q    <= wrdata_d;
            resp_data_q <= resp_data_d;
            byte_en_q   <= byte_en_d;
            lane_q      <= lane_d;
            funct3_q    <= funct3_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            misalign_q  <= misalign_d;
            illegal_q   <= illegal_d;
            stall_q     <= stall_d;
        end
    end

    assign o_req_ready     = (state_q == IDLE);
    assign o_ldst_rd       = (state_q == ACCESS) && !wr_q;
    assign o_ldst_wr       = (state_q == ACCESS) && wr_q;
    assign o_ldst_addr     = addr_q;
    assign o_ldst_wrdata   = wrdata_q;
    assign o_ldst_byte_en  = byte_en_q;
    assign o_resp_valid    = (state_q == RESP);
    assign o_resp_rd       = rd_q;
    assign o_resp_data     = resp_data_q;
    assign o_resp_misalign = (state_q == RESP) && misalign_q;
    assign o_resp_illegal  = (state_q == RESP) && illegal_q;
    assign o_stall_cycles  = stall_q;
endmodule

// File: tb/tb_ldst_unit.sv
// Randomized and directed bench for ldst_unit against a byte-arithmetic reference model.
module tb_ldst_unit;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req_valid, i_req_wr;
    logic [2:0]    i_req_funct3;
    logic [IW-1:0] i_req_base, i_req_offset, i_req_wrdata;
    logic [4:0]    i_req_rd;
    logic [IW-1:0] i_ldst_rddata;
    logic          i_ldst_waitrequest;

    logic          o_req_ready, o_resp_valid, o_resp_misalign, o_resp_illegal;
    logic [4:0]    o_resp_rd;
    logic [IW-1:0] o_resp_data, o_ldst_addr, o_ldst_wrdata;
    logic          o_ldst_rd, o_ldst_wr;
    logic [3:0]    o_ldst_byte_en;
    logic [15:0]   o_stall_cycles;

    logic          s_req_ready, s_resp_valid, s_resp_misalign, s_resp_illegal;
    logic [4:0]    s_resp_rd;
    logic [IW-1:0] s_resp_data, s_ldst_addr, s_ldst_wrdata;
    logic          s_ldst_rd, s_ldst_wr;
    logic [3:0]    s_ldst_byte_en;
    logic [1:0]    s_stall_cycles;

    always #5 clk = ~clk;

    ldst_unit #(.IW(IW), .STALLW(16)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
        .i_req_funct3(i_req_funct3), .i_req_base(i_req_base), .i_req_offset(i_req_offset),
        .i_req_wrdata(i_req_wrdata), .i_req_rd(i_req_rd),
        .o_resp_valid(o_resp_valid), .o_resp_rd(o_resp_rd), .o_resp_data(o_resp_data),
        .o_resp_misalign(o_resp_misalign), .o_resp_illegal(o_resp_illegal),
        .o_ldst_addr(o_ldst_addr), .o_ldst_rd(o_ldst_rd), .o_ldst_wr(o_ldst_wr),
        .o_ldst_wrdata(o_ldst_wrdata), .o_ldst_byte_en(o_ldst_byte_en),
        .i_ldst_rddata(i_ldst_rddata), .i_ldst_waitrequest(i_ldst_waitrequest),
        .o_stall_cycles(o_stall_cycles)
    );

    ldst_unit #(.IW(IW), .STALLW(2)) dut_sat (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .o_req_ready(s_req_ready), .i_req_wr(i_req_wr),
        .i_req_funct3(i_req_funct3), .i_req_base(i_req_base), .i_req_offset(i_req_offset),
        .i_req_wrdata(i_req_wrdata), .i_req_rd(i_req_rd),
        .o_resp_valid(s_resp_valid), .o_resp_rd(s_resp_rd), .o_resp_data(s_resp_data),
        .o_resp_misalign(s_resp_misalign), .o_resp_illegal(s_resp_illegal),
        .o_ldst_addr(s_ldst_addr), .o_ldst_rd(s_ldst_rd), .o_ldst_wr(s_ldst_wr),
        .o_ldst_wrdata(s_ldst_wrdata), .o_ldst_byte_en(s_ldst_byte_en),
        .i_ldst_rddata(i_ldst_rddata), .i_ldst_waitrequest(i_ldst_waitrequest),
        .o_stall_cycles(s_stall_cycles)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int stall_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One request end to end: model computes the expected strobes, lanes and response.
    task automatic txn(input bit wr, input bit [2:0] f3, input bit [31:0] base, input bit [31:0] off,
                       input bit [31:0] wdat, input bit [4:0] rd, input int stalls, input bit [31:0] rdat);
        bit [31:0] ea, ewd, edata;
        bit [3:0]  be;
        int        lane, size, lat;
        bit        legal, mis, acc;
        longint    v;
        ea    = base + off;
        lane  = int'(ea % 4);
        size  = 1 << f3[1:0];
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = legal && ((ea % size) != 0);
        be    = 4'(((1 << size) - 1) << lane);
        ewd   = wdat << (8 * lane);
        v     = (longint'(rdat) >> (8 * lane)) & ((longint'(1) << (8 * size)) - 1);
        if (f3 < 3'd4 && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
        edata = (wr || !legal || mis || rd == 5'd0) ? 32'd0 : v[31:0];
        lat   = (legal && !mis) ? stalls + 2 : 1;
        if (legal && !mis) stall_total += stalls;

        @(negedge clk);
        check("ready_idle", o_req_ready, 1);
        i_req_valid = 1'b1; i_req_wr = wr; i_req_funct3 = f3; i_req_base = base;
        i_req_offset = off; i_req_wrdata = wdat; i_req_rd = rd;
        @(posedge clk); #1;
        i_req_valid = 1'($urandom); i_req_wr = 1'($urandom); i_req_funct3 = 3'($urandom);
        i_req_base = $urandom; i_req_offset = $urandom; i_req_wrdata = $urandom; i_req_rd = 5'($urandom);
        i_ldst_waitrequest = (stalls > 0);
        i_ldst_rddata = (stalls > 0) ? $urandom : rdat;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            acc = legal && !mis && (k < lat);
            check("ready_busy", o_req_ready, 0);
            check("rd_strobe", o_ldst_rd, acc && !wr);
            check("wr_strobe", o_ldst_wr, acc && wr);
            check("resp_valid", o_resp_valid, k == lat);
            if (acc) begin
                check("addr", o_ldst_addr, ea & 32'hFFFF_FFFC);
                check("byte_en", o_ldst_byte_en, be);
                check("wrdata", o_ldst_wrdata, ewd);
            end
            if (k == lat) begin
                check("resp_rd", o_resp_rd, rd);
                check("resp_data", o_resp_data, edata);
                check("misalign", o_resp_misalign, mis);
                check("illegal", o_resp_illegal, !legal);
                check("stall_cnt", o_stall_cycles, (stall_total > 65535) ? 65535 : stall_total);
                check("stall_sat", s_stall_cycles, (stall_total > 3) ? 3 : stall_total);
                i_req_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
                i_ldst_waitrequest = (k + 1 <= stalls);
                i_ldst_rddata = i_ldst_waitrequest ? $urandom : rdat;
            end
        end
    endtask

    initial begin
        reset = 1'b1; i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_funct3 = '0;
        i_req_base = '0; i_req_offset = '0; i_req_wrdata = '0; i_req_rd = '0;
        i_ldst_rddata = '0; i_ldst_waitrequest = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_rd", o_ldst_rd, 0);
        check("rst_wr", o_ldst_wr, 0);
        check("rst_valid", o_resp_valid, 0);
        check("rst_addr", o_ldst_addr, 0);
        check("rst_data", o_resp_data, 0);
        check("rst_stall", o_stall_cycles, 0);
        reset = 1'b0;

        txn(0, 3'd2, 32'h100, 32'h4, $urandom, 5'd5, 0, 32'h1234_5678);
        txn(0, 3'd0, 32'h100, 32'h3, $urandom, 5'd1, 0, 32'h8000_0000);
        txn(0, 3'd4, 32'h100, 32'h3, $urandom, 5'd1, 0, 32'h8000_0000);
        txn(1, 3'd1, 32'h100, 32'h2, 32'h0000_ABCD, 5'd3, 0, $urandom);
        txn(0, 3'd2, 32'h100, 32'h2, $urandom, 5'd4, 0, $urandom);
        txn(0, 3'd7, 32'h100, 32'h0, $urandom, 5'd4, 0, $urandom);
        txn(0, 3'd2, 32'h100, 32'h0, $urandom, 5'd6, 3, 32'hCAFE_F00D);
        txn(0, 3'd2, 32'h100, 32'h0, $urandom, 5'd6, 3, 32'hCAFE_F00D);
        txn(0, 3'd5, 32'h200, 32'h2, $urandom, 5'd0, 1, 32'hFFFF_0000);

        // Reset in the middle of a stalled load.
        @(negedge clk);
        i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_funct3 = 3'd2; i_req_base = 32'h300;
        i_req_offset = 32'h0; i_req_rd = 5'd7;
        @(posedge clk); #1;
        i_req_valid = 1'b0; i_ldst_waitrequest = 1'b1;
        @(negedge clk);
        check("pre_rst_rd", o_ldst_rd, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rd", o_ldst_rd, 0);
        check("async_addr", o_ldst_addr, 0);
        check("async_stall", o_stall_cycles, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; i_ldst_waitrequest = 1'b0; stall_total = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_valid", o_resp_valid, 0);
            check("post_rst_ready", o_req_ready, 1);
        end

        for (int t = 0; t < 300; t++) begin
            bit [31:0] b;
            b = $urandom;
            if ($urandom_range(0, 1) == 0) b[1:0] = 2'b00;
            txn(1'($urandom), 3'($urandom_range(0, 7)), b, 32'($urandom_range(0, 15)),
                $urandom, 5'($urandom), $urandom_range(0, 3), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ldst_unit.md
LDST_UNIT -- requirements
Module: ldst_unit

Interface
REQ-001 SHALL have parameters: IW, default 32, data/address width, legal values 32 or 64 only; STALLW, default 16, stall-counter width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  core issues a load/store.
- o_req_ready  out  1  unit can accept a request.
- i_req_wr  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  RISC-V size/sign code.
- i_req_base  in  IW  rs1 value.
- i_req_offset  in  IW  sign-extended immediate.
- i_req_wrdata  in  IW  rs2 value.
- i_req_rd  in  5  load destination.
- o_resp_valid  out  1  one-cycle completion pulse.
- o_resp_rd  out  5  destination echo.
- o_resp_data  out  IW  extended load data.
- o_resp_misalign  out  1  misaligned-access fault.
- o_resp_illegal  out  1  illegal-funct3 fault.
- o_ldst_addr  out  IW  lane-aligned address.
- o_ldst_rd  out  1  memory read strobe.
- o_ldst_wr  out  1  memory write strobe.
- o_ldst_wrdata  out  IW  lane-shifted store data.
- o_ldst_byte_en  out  IW/8  byte lanes.
- i_ldst_rddata  in  IW  memory read data.
- i_ldst_waitrequest  in  1  memory stall.
- o_stall_cycles  out  STALLW  saturating waitrequest-cycle count.

Function
REQ-003 SHALL implement FSM IDLE, ACCESS, RESP; one request outstanding at most.
REQ-004 o_req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge with i_req_valid && o_req_ready.
REQ-005 On acceptance: EA = i_req_base + i_req_offset, modulo 2^IW; L = log2(IW/8); lane = EA[L-1:0]; o_ldst_addr = EA with low L bits cleared.
REQ-006 Legal load funct3: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu; additionally 3 ld and 6 lwu when IW=64. Legal store funct3: 0, 1, 2; additionally 3 when IW=64. All other codes are illegal.
REQ-007 Misaligned means access size (1/2/4/8 bytes) does not divide EA.
REQ-008 Illegal or misaligned request: IDLE->RESP with no memory strobe; o_resp_illegal takes priority and excludes o_resp_misalign.
REQ-009 Legal request: IDLE->ACCESS. o_ldst_byte_en = size mask shifted left by lane. o_ldst_wrdata = i_req_wrdata shifted left by 8*lane bits.
REQ-010 In ACCESS: exactly one of o_ldst_rd/o_ldst_wr SHALL be 1. Address, byte_en and wrdata SHALL be held stable while i_ldst_waitrequest = 1.
REQ-011 ACCESS SHALL complete in the cycle where i_ldst_waitrequest = 0. Load data SHALL be captured from i_ldst_rddata in that same cycle. Next state is RESP.
REQ-012 Load data extraction: shift i_ldst_rddata right by 8*lane bits, then sign-extend (lb/lh/lw) or zero-extend (lbu/lhu/lwu) to IW; ld/IW-bit word passes unchanged.
REQ-013 RESP SHALL last one cycle with o_resp_valid = 1, then return to IDLE.
REQ-014 o_resp_data SHALL be 0 for stores, faults, and loads with rd = 0. o_resp_rd SHALL echo i_req_rd.
REQ-015 Latency from acceptance edge to o_resp_valid: 1 cycle for faults; 2 + (waitrequest-high cycles) for legal accesses.
REQ-016 o_stall_cycles SHALL increment each cycle in ACCESS with waitrequest = 1, and saturate at all-ones.
REQ-017 i_req_* inputs while not ready SHALL be ignored.

Reset
REQ-018 reset = 1 SHALL immediately force: state IDLE; o_ldst_rd, o_ldst_wr, o_resp_valid, fault flags = 0; o_ldst_addr, o_ldst_wrdata, o_ldst_byte_en, o_resp_data, o_resp_rd, o_stall_cycles = 0.
REQ-019 Reset mid-ACCESS SHALL abandon the access with no response; o_req_ready = 1 from the first edge after reset deasserts.

Verification
REQ-020 lw base 0x100, offset 4, waitrequest 0, rddata 0x12345678 -> addr 0x104, byte_en 1111, rd pulse 1 cycle, resp at acceptance+2 with data 0x12345678.
REQ-021 lb at EA 0x103, rddata 0x80000000 -> byte_en 1000, data 0xFFFFFF80; same access as lbu -> data 0x00000080.
REQ-022 sh at EA 0x102, wrdata 0x0000ABCD -> addr 0x100, byte_en 1100, wrdata 0xABCD0000, resp data 0.
REQ-023 lw at EA 0x102 -> no strobe, resp at acceptance+1 with misalign 1; load funct3 7 -> illegal 1, misalign 0.
REQ-024 waitrequest high 3 cycles on lw -> strobe and address stable, resp at acceptance+5, o_stall_cycles +3; with STALLW=2, repeated stalls hold the count at 3.
REQ-025 reset asserted during stalled ACCESS -> o_ldst_rd drops asynchronously, no o_resp_valid, ready after release.
